impulse_feeder: RTL and testbench
=================================

IMPULSE_FEEDER -- requirements
Module: impulse_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port `clock`: input, 1 bit, rising-edge system clock.
REQ-003 Port `reset_`: input, 1 bit, asynchronous reset, asserted at 1, not at 0.
REQ-004 Port `in_data`: input, 8 bits, value offered by the upstream source.
REQ-005 Port `in_dav_`: input, 1 bit, upstream data-available, active-low.
REQ-006 Port `in_rfd`: output, 1 bit, ready-for-data to upstream, active-high.
REQ-007 Port `numero`: output, 8 bits, registered pulse length to the impulse generator.
REQ-008 Port `dav_`: output, 1 bit, data-available to the generator, active-low.
REQ-009 Port `rfd`: input, 1 bit, ready-for-data from the generator.
REQ-010 Port `level`: output, 3 bits, FIFO occupancy, 0..4.
REQ-011 Port `drops`: output, 8 bits, count of zero values discarded.

Function
REQ-012 The block SHALL buffer values in a 4-entry, 8-bit FIFO between the upstream and downstream /dav-rfd handshakes.
REQ-013 Input FSM states SHALL be I_WAIT and I_ACK.
- I_WAIT: `in_rfd` = 1 iff `level` < 4.
- I_ACK: `in_rfd` = 0.
REQ-014 In I_WAIT with `in_dav_`=0 and `level`<4, the block SHALL capture `in_data` at the clock edge and move to I_ACK; it SHALL push the value unless it is 0.
REQ-015 A captured value of 0 SHALL NOT be pushed; `drops` SHALL increment, wrapping 255->0; the handshake completes normally.
REQ-016 In I_ACK the FSM SHALL return to I_WAIT at the first edge with `in_dav_`=1.
REQ-017 With `level`=4, I_WAIT SHALL hold `in_rfd`=0 and ignore `in_dav_`=0 until a pop frees an entry.
REQ-018 Output FSM states SHALL be O_IDLE, O_SEND and O_REL.
REQ-019 O_IDLE: `dav_`=1; at an edge with `level`>0 and `rfd`=1, the block SHALL load FIFO head into `numero` and go to O_SEND.
REQ-020 O_SEND: `dav_`=0 and `numero` held stable; at the first edge with `rfd`=0, the block SHALL pop the head and go to O_REL.
REQ-021 O_REL: `dav_`=1; at the first edge with `rfd`=1, the block SHALL return to O_IDLE.
REQ-022 `numero` SHALL retain its last value outside O_SEND.
REQ-023 Push and pop in the same cycle SHALL leave `level` unchanged and preserve FIFO order.
REQ-024 A push at edge k into an empty FIFO SHALL allow `dav_`=0 no earlier than after edge k+1.
REQ-025 Values SHALL be delivered in arrival order with no loss or duplication.
REQ-026 `level` SHALL never exceed 4 or go below 0.

Reset
REQ-027 While `reset_`=1, and immediately on assertion, the block SHALL force:
- FIFO empty, `level`=0, `drops`=0;
- I_WAIT, `in_rfd`=1;
- O_IDLE, `dav_`=1, `numero`=0.
REQ-028 Reset asserted mid-handshake SHALL abort both handshakes and discard all buffered values.
REQ-029 Normal operation SHALL start at the first rising edge after `reset_` returns to 0.

Structure
REQ-030 A shared package `impulse_pkg` SHALL hold:
- input and output FSM state encodings;
- FIFO depth (4) and data width (8).
REQ-031 The FIFO SHALL be one sub-module, `feeder_fifo`: push, pop, head, level; pointers wrap modulo 4.
REQ-032 Both FSMs, the `numero` register and the `drops` counter SHALL live in `impulse_feeder`.

Verification
REQ-033 Single value: push 5 with the generator idle -> `dav_`=0 with `numero`=5; after the `rfd`=0/1 cycle, `level`=0; the generator emits 5 high cycles.
REQ-034 Fill: push 3,7,2,9,4 with `rfd` held 0 -> `level`=4, `in_rfd`=0 and the 5th value stalls; releasing the generator delivers 3,7,2,9,4 in order.
REQ-035 Zero drop: push 0 then 6 -> `drops`=1, `level` peaks at 1, only 6 is delivered.
REQ-036 Simultaneous push and pop at `level`=2 -> `level` stays 2 and the next delivered value is correct.
REQ-037 Reset in O_SEND with `level`=3 -> immediately `dav_`=1, `numero`=0, `level`=0, `in_rfd`=1.
REQ-038 `drops` wrap: 256 zero pushes -> `drops`=0.

Source files
------------

// File: rtl/impulse_pkg.sv
// -----------------------------------------------------------------------------
// impulse_pkg
// Shared definitions for the impulse feeder: data/FIFO sizing, the handshake
// FSM state encodings and a couple of convenience types.
// -----------------------------------------------------------------------------
package impulse_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;   // log2(FIFO_DEPTH); pointers wrap modulo 4
    localparam int LEVEL_W    = 3;   // holds 0..FIFO_DEPTH

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t LEVEL_FULL = level_t'(FIFO_DEPTH);

    // Upstream (input) handshake FSM
    localparam logic [0:0] I_WAIT = 1'b0;
    localparam logic [0:0] I_ACK  = 1'b1;

    // Downstream (output) handshake FSM
    localparam logic [1:0] O_IDLE = 2'd0;
    localparam logic [1:0] O_SEND = 2'd1;
    localparam logic [1:0] O_REL  = 2'd2;

endpackage

// File: rtl/feeder_fifo.sv
// -----------------------------------------------------------------------------
// feeder_fifo
// 4-entry, 8-bit FIFO used between the upstream and generator handshakes.
// Push is ignored when full, pop is ignored when empty. A simultaneous push
// and pop leaves the occupancy unchanged.
//
// Ports
//   clock      rising-edge clock
//   reset_     asynchronous reset, active high; empties the FIFO
//   push       write push_data at the tail
//   push_data  value to write
//   pop        discard the head entry
//   head       current head entry (valid while level > 0)
//   level      occupancy, 0..4
// -----------------------------------------------------------------------------
import impulse_pkg::*;

module feeder_fifo (
    input  logic   clock,
    input  logic   reset_,
    input  logic   push,
    input  data_t  push_data,
    input  logic   pop,
    output data_t  head,
    output level_t level
);

    data_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    level_t            count;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full    = (count == LEVEL_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/impulse_feeder.sv
// -----------------------------------------------------------------------------
// impulse_feeder
// Buffers pulse lengths from an upstream /dav-rfd source into a 4-deep FIFO
// and hands them one at a time to an impulse generator over a second
// /dav-rfd handshake. Zero values are accepted but discarded and counted.
//
// Ports
//   clock     rising-edge system clock
//   reset_    asynchronous reset, active high
//   in_data   value offered by the upstream source
//   in_dav_   upstream data-available, active low
//   in_rfd    ready-for-data to upstream, active high
//   numero    registered pulse length to the generator
//   dav_      data-available to the generator, active low
//   rfd       ready-for-data from the generator
//   level     FIFO occupancy, 0..4
//   drops     count of discarded zero values (wraps)
//
// Input FSM
//   state   | meaning
//   I_WAIT  | ready for a value whenever the FIFO has room
//   I_ACK   | value taken, waiting for upstream to release in_dav_
//
// Output FSM
//   state   | meaning
//   O_IDLE  | no offer; waits for data and a ready generator
//   O_SEND  | numero offered with dav_ low until the generator drops rfd
//   O_REL   | entry consumed; waits for the generator to raise rfd again
// -----------------------------------------------------------------------------
import impulse_pkg::*;

module impulse_feeder (
    input  logic        clock,
    input  logic        reset_,
    input  logic [7:0]  in_data,
    input  logic        in_dav_,
    output logic        in_rfd,
    output logic [7:0]  numero,
    output logic        dav_,
    input  logic        rfd,
    output logic [2:0]  level,
    output logic [7:0]  drops
);

    logic [0:0] in_state;
    logic [1:0] out_state;

    logic   has_room;
    logic   accept;
    logic   push;
    logic   pop;
    data_t  fifo_head;
    level_t fifo_level;

    assign has_room = (fifo_level < LEVEL_FULL);
    assign accept   = (in_state == I_WAIT) && !in_dav_ && has_room;
    assign push     = accept && (in_data != '0);
    assign pop      = (out_state == O_SEND) && !rfd;

    feeder_fifo u_fifo (
        .clock     (clock),
        .reset_    (reset_),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .level     (fifo_level)
    );

    // Input handshake
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            in_state <= I_WAIT;
        end else begin
            case (in_state)
                I_WAIT:  if (accept) in_state <= I_ACK;
                I_ACK:   if (in_dav_) in_state <= I_WAIT;
                default: in_state <= I_WAIT;
            endcase
        end
    end

    // A zero is a complete handshake that just never reaches the FIFO.
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            drops <= '0;
        end else if (accept && (in_data == '0)) begin
            drops <= drops + 1'b1;
        end
    end

    // Output handshake. numero is only reloaded on the O_IDLE -> O_SEND
    // transition, so it holds steady for the whole offer and afterwards.
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            out_state <= O_IDLE;
            numero    <= '0;
        end else begin
            case (out_state)
                O_IDLE: begin
                    if ((fifo_level != '0) && rfd) begin
                        numero    <= fifo_head;
                        out_state <= O_SEND;
                    end
                end
                O_SEND:  if (!rfd) out_state <= O_REL;
                O_REL:   if (rfd)  out_state <= O_IDLE;
                default: out_state <= O_IDLE;
            endcase
        end
    end

    assign in_rfd = (in_state == I_WAIT) && has_room;
    assign dav_   = (out_state != O_SEND);
    assign level  = fifo_level;

endmodule

// File: tb/tb_impulse_feeder.sv
module tb_impulse_feeder;

    logic       clock;
    logic       reset_;
    logic [7:0] in_data;
    logic       in_dav_;
    logic       in_rfd;
    logic [7:0] numero;
    logic       dav_;
    logic       rfd;
    logic [2:0] level;
    logic [7:0] drops;

    int vectors;
    int miscompares;

    impulse_feeder dut (
        .clock   (clock),
        .reset_  (reset_),
        .in_data (in_data),
        .in_dav_ (in_dav_),
        .in_rfd  (in_rfd),
        .numero  (numero),
        .dav_    (dav_),
        .rfd     (rfd),
        .level   (level),
        .drops   (drops)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full upstream handshake for one value.
    task automatic push_val(input logic [7:0] v);
        int n;
        n = 0;
        while (in_rfd !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL push_wait: in_rfd=%b never rose, required 1", in_rfd);
        end
        in_data = v;
        in_dav_ = 1'b0;
        tick();
        in_dav_ = 1'b1;
        tick();
    endtask

    // Acts as the impulse generator: waits for an offer, checks it, drops rfd
    // for exp cycles (the pulse) and raises rfd again.
    task automatic recv(input logic [7:0] exp, input string name);
        int n;
        n = 0;
        rfd = 1'b1;
        while (dav_ !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 50) begin
            miscompares++;
            $display("FAIL %s_offer: dav_=%b never fell, required 0", name, dav_);
            return;
        end
        if (numero !== exp) begin
            miscompares++;
            $display("FAIL %s_numero: got %0d, required %0d", name, numero, exp);
        end
        rfd = 1'b0;
        tick();
        vectors++;
        if (dav_ !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_release: dav_=%b, required 1", name, dav_);
        end
        for (int i = 1; i < exp; i++) tick();
        vectors++;
        if (numero !== exp) begin
            miscompares++;
            $display("FAIL %s_hold: numero=%0d, required %0d", name, numero, exp);
        end
        rfd = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_  = 1'b1;
        in_data = 8'h00;
        in_dav_ = 1'b1;
        rfd     = 1'b1;
        #1;
        vectors += 5;
        if (level !== 3'd0)  begin miscompares++; $display("FAIL rst_level: got %0d, required 0", level); end
        if (drops !== 8'd0)  begin miscompares++; $display("FAIL rst_drops: got %0d, required 0", drops); end
        if (in_rfd !== 1'b1) begin miscompares++; $display("FAIL rst_in_rfd: got %b, required 1", in_rfd); end
        if (dav_ !== 1'b1)   begin miscompares++; $display("FAIL rst_dav: got %b, required 1", dav_); end
        if (numero !== 8'd0) begin miscompares++; $display("FAIL rst_numero: got %0d, required 0", numero); end
        @(negedge clock);
        @(negedge clock);
        reset_ = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rfd     = 1'b1;
        in_data = 8'd5;
        in_dav_ = 1'b0;
        tick();
        vectors += 3;
        if (dav_ !== 1'b1)   begin miscompares++; $display("FAIL single_early_dav: got %b, required 1", dav_); end
        if (level !== 3'd1)  begin miscompares++; $display("FAIL single_level1: got %0d, required 1", level); end
        if (in_rfd !== 1'b0) begin miscompares++; $display("FAIL single_ack_rfd: got %b, required 0", in_rfd); end
        in_dav_ = 1'b1;
        tick();
        vectors += 2;
        if (dav_ !== 1'b0)   begin miscompares++; $display("FAIL single_dav: got %b, required 0", dav_); end
        if (numero !== 8'd5) begin miscompares++; $display("FAIL single_numero: got %0d, required 5", numero); end
        recv(8'd5, "single");
        vectors++;
        if (level !== 3'd0)  begin miscompares++; $display("FAIL single_level0: got %0d, required 0", level); end
    endtask

    task automatic test_fill();
        logic [7:0] exp_q [5];
        exp_q = '{8'd3, 8'd7, 8'd2, 8'd9, 8'd4};
        rfd = 1'b0;
        for (int i = 0; i < 4; i++) push_val(exp_q[i]);
        vectors += 2;
        if (level !== 3'd4)  begin miscompares++; $display("FAIL fill_level: got %0d, required 4", level); end
        if (in_rfd !== 1'b0) begin miscompares++; $display("FAIL fill_in_rfd: got %b, required 0", in_rfd); end
        in_data = exp_q[4];
        in_dav_ = 1'b0;
        tick(); tick(); tick();
        vectors += 2;
        if (level !== 3'd4)  begin miscompares++; $display("FAIL fill_stall_level: got %0d, required 4", level); end
        if (in_rfd !== 1'b0) begin miscompares++; $display("FAIL fill_stall_rfd: got %b, required 0", in_rfd); end
        recv(exp_q[0], "fill0");
        in_dav_ = 1'b1;
        vectors++;
        if (level !== 3'd4)  begin miscompares++; $display("FAIL fill_refill: got %0d, required 4", level); end
        for (int i = 1; i < 5; i++) recv(exp_q[i], $sformatf("fill%0d", i));
        vectors += 2;
        if (level !== 3'd0)  begin miscompares++; $display("FAIL fill_empty: got %0d, required 0", level); end
        if (drops !== 8'd0)  begin miscompares++; $display("FAIL fill_drops: got %0d, required 0", drops); end
    endtask

    task automatic test_zero_drop();
        rfd = 1'b0;
        push_val(8'd0);
        vectors += 2;
        if (drops !== 8'd1)  begin miscompares++; $display("FAIL zero_drops: got %0d, required 1", drops); end
        if (level !== 3'd0)  begin miscompares++; $display("FAIL zero_level0: got %0d, required 0", level); end
        push_val(8'd6);
        vectors++;
        if (level !== 3'd1)  begin miscompares++; $display("FAIL zero_level1: got %0d, required 1", level); end
        recv(8'd6, "zero");
        tick(); tick();
        vectors += 2;
        if (level !== 3'd0)  begin miscompares++; $display("FAIL zero_after_level: got %0d, required 0", level); end
        if (dav_ !== 1'b1)   begin miscompares++; $display("FAIL zero_after_dav: got %b, required 1", dav_); end
    endtask

    task automatic test_back_to_back();
        rfd = 1'b0;
        push_val(8'd11);
        push_val(8'd12);
        rfd = 1'b1;
        tick();
        vectors += 2;
        if (dav_ !== 1'b0)    begin miscompares++; $display("FAIL b2b_dav: got %b, required 0", dav_); end
        if (numero !== 8'd11) begin miscompares++; $display("FAIL b2b_numero: got %0d, required 11", numero); end
        rfd     = 1'b0;
        in_data = 8'd13;
        in_dav_ = 1'b0;
        tick();
        vectors++;
        if (level !== 3'd2)   begin miscompares++; $display("FAIL b2b_level: got %0d, required 2", level); end
        in_dav_ = 1'b1;
        rfd     = 1'b1;
        tick();
        recv(8'd12, "b2b_next");
        recv(8'd13, "b2b_last");
        vectors++;
        if (level !== 3'd0)   begin miscompares++; $display("FAIL b2b_empty: got %0d, required 0", level); end
    endtask

    task automatic test_reset_mid();
        rfd = 1'b0;
        push_val(8'd21);
        push_val(8'd22);
        push_val(8'd23);
        rfd = 1'b1;
        tick();
        vectors += 2;
        if (dav_ !== 1'b0)  begin miscompares++; $display("FAIL rmid_pre_dav: got %b, required 0", dav_); end
        if (level !== 3'd3) begin miscompares++; $display("FAIL rmid_pre_level: got %0d, required 3", level); end
        in_data = 8'd24;
        in_dav_ = 1'b0;
        #2;
        reset_ = 1'b1;
        #1;
        vectors += 5;
        if (dav_ !== 1'b1)   begin miscompares++; $display("FAIL rmid_dav: got %b, required 1", dav_); end
        if (numero !== 8'd0) begin miscompares++; $display("FAIL rmid_numero: got %0d, required 0", numero); end
        if (level !== 3'd0)  begin miscompares++; $display("FAIL rmid_level: got %0d, required 0", level); end
        if (in_rfd !== 1'b1) begin miscompares++; $display("FAIL rmid_in_rfd: got %b, required 1", in_rfd); end
        if (drops !== 8'd0)  begin miscompares++; $display("FAIL rmid_drops: got %0d, required 0", drops); end
        in_dav_ = 1'b1;
        @(negedge clock);
        reset_ = 1'b0;
        tick();
        push_val(8'd30);
        recv(8'd30, "rmid_new");
        vectors++;
        if (level !== 3'd0)  begin miscompares++; $display("FAIL rmid_empty: got %0d, required 0", level); end
    endtask

    task automatic test_drops_wrap();
        rfd = 1'b0;
        for (int i = 0; i < 255; i++) push_val(8'd0);
        vectors++;
        if (drops !== 8'd255) begin miscompares++; $display("FAIL wrap_255: got %0d, required 255", drops); end
        push_val(8'd0);
        vectors += 2;
        if (drops !== 8'd0)   begin miscompares++; $display("FAIL wrap_0: got %0d, required 0", drops); end
        if (level !== 3'd0)   begin miscompares++; $display("FAIL wrap_level: got %0d, required 0", level); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_fill();
        test_zero_drop();
        test_back_to_back();
        test_reset_mid();
        test_drops_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
